// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types and helpers for the multiplier arbiter.
//   OP_W        operand width of the shared multiplier
//   RES_W       product width
//   ID_MAX_W    requester-ID width stored in the response FIFO (covers up to 8 requesters)
//   rsp_entry_t one response FIFO entry {id, data}
//   next_rr()   round-robin pointer rotation
package mul_arb_pkg;

    localparam int unsigned OP_W     = 8;
    localparam int unsigned RES_W    = 16;
    localparam int unsigned ID_MAX_W = 3;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [RES_W-1:0]    data;
    } rsp_entry_t;

    // Advance a round-robin pointer by one, wrapping at num_req.
    function automatic logic [ID_MAX_W-1:0] next_rr(input logic [ID_MAX_W-1:0] ptr,
                                                    input int unsigned         num_req);
        if (32'(ptr) + 32'd1 >= num_req) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/mul_arb_rsp_fifo.sv
// mul_arb_rsp_fifo: synchronous response FIFO. The head entry is read straight from
// storage (no output register), so it is visible in the cycle after it is pushed.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (clears storage too)
//   push_i         write push_data_i at the tail
//   push_data_i    entry to write
//   pop_i          drop the head entry
//   head_o         current head entry
//   count_o        number of stored entries
//   full_o/empty_o occupancy flags
module mul_arb_rsp_fifo
    import mul_arb_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = rsp_entry_t,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // On a full FIFO with a simultaneous pop, wr_ptr == rd_ptr: the head is
            // consumed this cycle, so overwriting its slot at the edge is safe.
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one 8x8->16 multiplier between NUM_REQ requesters.
// Round-robin grant (at most one issue per cycle), operand registers feeding the
// multiplier, a valid/ID tag pipe matching the multiplier latency, and a response
// FIFO whose head drives the tagged, backpressured response channel. Issue is
// credit-limited so the FIFO can never overflow.
// Optional feature (macro MUL_ARB_STATS_EN): stat_issued_o / stat_stall_o counters.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  per-requester handshake (ready one-hot or zero)
//   req_a_i/req_b_i        packed operands, requester i at [8i+7:8i]
//   mul_in1_o/mul_in2_o    registered operands to the multiplier
//   mul_out_i              product from the multiplier
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_id_o/rsp_data_o    requester index and product of the head response
//   stat_issued_o          accepted-request count (MUL_ARB_STATS_EN only)
//   stat_stall_o           cycles with a request but no grant (MUL_ARB_STATS_EN only)
//   busy_o                 operation in flight or response queued
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MUL_LAT   = 1,
    parameter int unsigned RSP_DEPTH = 4,
    localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*OP_W-1:0] req_a_i,
    input  logic [NUM_REQ*OP_W-1:0] req_b_i,
    output logic [OP_W-1:0]         mul_in1_o,
    output logic [OP_W-1:0]         mul_in2_o,
    input  logic [RES_W-1:0]        mul_out_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [ID_W-1:0]         rsp_id_o,
    output logic [RES_W-1:0]        rsp_data_o,
`ifdef MUL_ARB_STATS_EN
    output logic [31:0]             stat_issued_o,
    output logic [31:0]             stat_stall_o,
`endif
    output logic                    busy_o
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    // Arbitration / issue
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_idx, cand;
    logic               grant_found;
    logic               credit_ok;
    logic               accept;
    logic [OP_W-1:0]    mul_in1_q, mul_in2_q;
    int unsigned        inflight_cnt;
    int unsigned        slots_used;

    // Tag pipe
    logic [MUL_LAT-1:0] pipe_valid_q;
    logic [ID_W-1:0]    pipe_id_q [MUL_LAT];

    // Response FIFO
    rsp_entry_t         fifo_push_data;
    rsp_entry_t         fifo_head;
    logic               fifo_push, fifo_pop;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty;

    // Round-robin search from rr_ptr_q, which holds last_grant+1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = ID_W'((32'(rr_ptr_q) + off) % NUM_REQ);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Every in-flight op and every queued response holds a FIFO slot; a pop this
    // cycle frees one before the new issue lands.
    always_comb begin
        inflight_cnt = 0;
        for (int i = 0; i < MUL_LAT; i++) begin
            inflight_cnt += 32'(pipe_valid_q[i]);
        end
        slots_used = inflight_cnt + 32'(fifo_count) - 32'(fifo_pop);
        credit_ok  = (slots_used < RSP_DEPTH);
    end

    // rst_n gates ready so no handshake is reported while state is held in reset.
    assign accept = grant_found && credit_ok && rst_n;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = ID_W'(next_rr(ID_MAX_W'(grant_idx), NUM_REQ));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            mul_in1_q <= '0;
            mul_in2_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (accept) begin
                mul_in1_q <= req_a_i[grant_idx*OP_W +: OP_W];
                mul_in2_q <= req_b_i[grant_idx*OP_W +: OP_W];
            end
        end
    end

    assign mul_in1_o = mul_in1_q;
    assign mul_in2_o = mul_in2_q;

    // Stage 0 lines up with the cycle the operands sit on mul_in*; the last stage
    // lines up with the cycle mul_out_i carries that op's product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_id_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= accept;
            pipe_id_q[0]    <= grant_idx;
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_id_q[i]    <= pipe_id_q[i-1];
            end
        end
    end

    assign fifo_push           = pipe_valid_q[MUL_LAT-1];
    assign fifo_push_data.id   = ID_MAX_W'(pipe_id_q[MUL_LAT-1]);
    assign fifo_push_data.data = mul_out_i;
    assign fifo_pop            = !fifo_empty && rsp_ready_i;

    mul_arb_rsp_fifo #(
        .DEPTH   (RSP_DEPTH),
        .entry_t (rsp_entry_t)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rsp_valid_o = !fifo_empty;
    assign rsp_id_o    = ID_W'(fifo_head.id);
    assign rsp_data_o  = fifo_head.data;
    assign busy_o      = (|pipe_valid_q) || !fifo_empty;

    // Credit must keep a result from ever arriving at a full FIFO without a pop.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready_o));

`ifdef MUL_ARB_STATS_EN
    logic [31:0] stat_issued_q, stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_q + 32'(accept);
            stat_stall_q  <= stat_stall_q + 32'((|req_valid_i) && !accept);
        end
    end

    assign stat_issued_o = stat_issued_q;
    assign stat_stall_o  = stat_stall_q;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: self-checking bench for mul_arbiter (default 4 requesters,
// combinational multiplier, 4-entry response FIFO). A transaction-level model
// (queue of outstanding results with visibility times) checks every cycle; table
// vectors and hand sequences cover latency, rotation, backpressure and reset.
module tb_mul_arbiter;

    localparam int N     = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready_o;
    logic [N*8-1:0]   req_a, req_b;
    logic [7:0]       mul_in1_o, mul_in2_o;
    logic [15:0]      mul_out;
    logic             rsp_valid_o;
    logic             rsp_ready;
    logic [1:0]       rsp_id_o;
    logic [15:0]      rsp_data_o;
    logic             busy_o;
`ifdef MUL_ARB_STATS_EN
    logic [31:0]      stat_issued_o, stat_stall_o;
    int               exp_issued, exp_stall;
`endif

    always #5 clk = ~clk;

    // Combinational multiplier stand-in.
    assign mul_out = 16'(mul_in1_o) * 16'(mul_in2_o);

    mul_arbiter #(
        .NUM_REQ   (N),
        .MUL_LAT   (LAT),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .mul_in1_o     (mul_in1_o),
        .mul_in2_o     (mul_in2_o),
        .mul_out_i     (mul_out),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id_o),
        .rsp_data_o    (rsp_data_o),
`ifdef MUL_ARB_STATS_EN
        .stat_issued_o (stat_issued_o),
        .stat_stall_o  (stat_stall_o),
`endif
        .busy_o        (busy_o)
    );

    // Model state: outstanding results in issue order, each with the cycle it
    // becomes visible on the response port.
    typedef struct {
        int id;
        int data;
        int vis;
    } exp_t;

    exp_t       q[$];
    int         cyc;
    int         ptr;
    logic [7:0] last_a, last_b;

    // Observations from the most recent cycle().
    int         acc_id;
    bit         o_rv;
    int         o_id, o_data;
    logic [N-1:0] o_ready;

    int n_vec, n_err;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ptr    = 0;
        last_a = '0;
        last_b = '0;
`ifdef MUL_ARB_STATS_EN
        exp_issued = 0;
        exp_stall  = 0;
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready_o), 0);
        chk({tag, "_mul_in1"},   32'(mul_in1_o), 0);
        chk({tag, "_mul_in2"},   32'(mul_in2_o), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 0);
        chk({tag, "_rsp_id"},    32'(rsp_id_o), 0);
        chk({tag, "_rsp_data"},  32'(rsp_data_o), 0);
        chk({tag, "_busy"},      32'(busy_o), 0);
`ifdef MUL_ARB_STATS_EN
        chk({tag, "_stat_issued"}, stat_issued_o, 0);
        chk({tag, "_stat_stall"},  stat_stall_o, 0);
`endif
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        bit           exp_rv, pop, credit;
        int           g, idx;
        logic [N-1:0] exp_ready;
        #2;
        exp_rv  = (q.size() > 0) && (q[0].vis <= cyc);
        o_rv    = rsp_valid_o;
        o_id    = int'(rsp_id_o);
        o_data  = int'(rsp_data_o);
        o_ready = req_ready_o;
        chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rv));
        if (exp_rv && rsp_valid_o) begin
            chk("rsp_id", 32'(rsp_id_o), q[0].id);
            chk("rsp_data", 32'(rsp_data_o), q[0].data);
        end
        pop    = exp_rv && rsp_ready;
        credit = (q.size() - int'(pop)) < DEPTH;
        g = -1;
        for (int off = 0; off < N; off++) begin
            idx = (ptr + off) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_ready = '0;
        if (credit && g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready_o), 32'(exp_ready));
        chk("busy", 32'(busy_o), 32'(q.size() > 0));
        chk("mul_in1", 32'(mul_in1_o), 32'(last_a));
        chk("mul_in2", 32'(mul_in2_o), 32'(last_b));
`ifdef MUL_ARB_STATS_EN
        if (credit && g >= 0) exp_issued++;
        else if (req_valid != '0) exp_stall++;
`endif
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        acc_id = -1;
        if (credit && g >= 0) begin
            last_a = req_a[g*8 +: 8];
            last_b = req_b[g*8 +: 8];
            q.push_back('{g, int'(last_a) * int'(last_b), cyc + LAT + 1});
            ptr    = (g + 1) % N;
            acc_id = g;
        end
        cyc++;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_reset_vals("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 30 && q.size() > 0; t++) cycle();
        chk("drain_left", 32'(q.size()), 0);
        cycle();
    endtask

    initial begin
        int hs, got, k, accepts, pops, seq;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        req_a = '0;
        req_b = '0;
        model_reset();

        tbl[0] = '{0, 8'd12,  8'd13,  16'd156};
        tbl[1] = '{1, 8'd255, 8'd255, 16'hFE01};
        tbl[2] = '{2, 8'd0,   8'd200, 16'd0};
        tbl[3] = '{3, 8'd16,  8'd16,  16'd256};
        tbl[4] = '{1, 8'd1,   8'd255, 16'd255};
        tbl[5] = '{3, 8'd128, 8'd2,   16'd256};
        tbl[6] = '{2, 8'd200, 8'd100, 16'd20000};

        #1;
        do_reset();

        // Single-requester transactions: latency, ID and product from the table.
        foreach (tbl[v]) begin
            rsp_ready = 1'b1;
            req_valid = '0;
            req_valid[tbl[v].id] = 1'b1;
            req_a[tbl[v].id*8 +: 8] = tbl[v].a;
            req_b[tbl[v].id*8 +: 8] = tbl[v].b;
            hs = -1;
            for (int t = 0; t < 10 && hs < 0; t++) begin
                k = cyc;
                cycle();
                if (acc_id == tbl[v].id) hs = k;
            end
            req_valid = '0;
            chk("tbl_accepted", 32'(hs >= 0), 1);
            got = 0;
            for (int t = 0; t < 10 && got == 0; t++) begin
                k = cyc;
                cycle();
                if (o_rv) begin
                    got = 1;
                    chk("tbl_latency", 32'(k - hs), LAT + 1);
                    chk("tbl_id", 32'(o_id), tbl[v].id);
                    chk("tbl_data", 32'(o_data), 32'(tbl[v].prod));
                end
            end
            chk("tbl_rsp_seen", 32'(got), 1);
        end
        drain();

        // Only req2/req3: after grant 2 and idle cycles, 3 wins, then 2.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        cycle();
        chk("rr_first2", 32'(o_ready), 32'h4);
        req_valid = '0;
        repeat (3) cycle();
        req_valid = 4'b1100;
        cycle();
        chk("rr_next3", 32'(o_ready), 32'h8);
        cycle();
        chk("rr_then2", 32'(o_ready), 32'h4);
        cycle();
        chk("rr_again3", 32'(o_ready), 32'h8);
        drain();

        // All four requesting 0xFF*0xFF: grants rotate 0,1,2,3 and responses follow.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        req_a     = '1;
        req_b     = '1;
        seq       = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("rr_all", 32'(o_ready), 32'(1 << (i % N)));
            if (o_rv) begin
                chk("ff_data", 32'(o_data), 32'hFE01);
                chk("ff_order", 32'(o_id), seq % N);
                seq++;
            end
        end
        drain();

        // Backpressure: exactly DEPTH accepts, then blocked; release drains cleanly.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        req_a     = 32'h0403_0201;
        req_b     = 32'h2030_4050;
        accepts   = 0;
        pops      = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (o_ready != '0) accepts++;
        end
        chk("bp_accepts", 32'(accepts), DEPTH);
        chk("bp_blocked", 32'(o_ready), 0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (o_ready != '0) accepts++;
            if (o_rv) pops++;
        end
        req_valid = '0;
        for (int i = 0; i < 30 && q.size() > 0; i++) begin
            cycle();
            if (o_rv) pops++;
        end
        chk("bp_drained", 32'(q.size()), 0);
        chk("bp_balance", 32'(pops), 32'(accepts));

        // Reset while results sit in the pipe and the FIFO.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("post_rst_no_rsp", 32'(o_rv), 0);
        end

        // Random traffic against the model; operands held until accepted.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < N; r++) begin
                if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
                    req_valid[r]    = 1'b1;
                    req_a[r*8 +: 8] = 8'($urandom);
                    req_b[r*8 +: 8] = 8'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (acc_id >= 0) req_valid[acc_id] = 1'b0;
        end
        drain();

`ifdef MUL_ARB_STATS_EN
        #2;
        chk("stat_issued", stat_issued_o, 32'(exp_issued));
        chk("stat_stall", stat_stall_o, 32'(exp_stall));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
